// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment codes, digit encoder and FSM states for the coded data display
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Non-decimal nibbles never reach here in normal operation; they show blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter, MagW cycles per value
module bin2bcd_seq #(
    parameter int MagW = 5,
    parameter int BcdD = (MagW + 2) / 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [MagW-1:0]     bin,
    output logic                busy,
    output logic                done,
    output logic [4*BcdD-1:0]   bcd
);

    localparam int CntW = $clog2(MagW + 1);

    logic [MagW-1:0]   shreg;
    logic [4*BcdD-1:0] acc;
    logic [4*BcdD-1:0] adj;
    logic [CntW-1:0]   cnt;
    logic              run;

    always_comb begin
        adj = acc;
        for (int i = 0; i < BcdD; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // done marks the cycle whose edge performs the final shift
    assign done = run && (cnt == CntW'(MagW - 1));
    assign busy = run;
    assign bcd  = acc;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            run   <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
            acc   <= '0;
        end else if (start && !run) begin
            run   <= 1'b1;
            cnt   <= '0;
            shreg <= bin;
            acc   <= '0;
        end else if (run) begin
            acc   <= {adj[4*BcdD-2:0], shreg[MagW-1]};
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/coded_data_display.sv
// rtl/coded_data_display.sv - decodes a coded counter value and scans it onto a multiplexed 7-segment display
module coded_data_display
    import display_pkg::*;
#(
    parameter int    Size    = 5,
    parameter string Signed  = "No",
    parameter string Code    = "Str",
    parameter int    Digits  = 3,
    parameter int    ScanDiv = 1000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [Size-1:0]   Data,
    output logic [6:0]        Segments,
    output logic [Digits-1:0] DigitSel,
    output logic              Busy,
    output logic              Overflow
);

    localparam bit IsSigned = (Signed == "Yes");
    localparam bit IsStr    = (Code == "Str");
    localparam bit IsInv    = (Code == "Inv");
    localparam int MagW     = Size;
    localparam int BcdD     = (MagW + 2) / 3;
    localparam int NumD     = IsSigned ? Digits - 1 : Digits;
    localparam int IdxW     = $clog2(Digits);
    localparam int ScanW    = $clog2(ScanDiv);

    logic              raw_neg;
    logic              neg;
    logic [MagW-1:0]   mag;

    state_t            state;
    logic [Size-1:0]   last;
    logic              force_q;
    logic              neg_q;
    logic              start;
    logic              eng_busy;
    logic              conv_done;
    logic [4*BcdD-1:0] bcd;

    logic              ovf;
    logic              lead;
    logic [3:0]        nib;
    logic [6:0]        next_digit [Digits];
    logic [6:0]        digit_q    [Digits];

    logic [ScanW-1:0]  scan_cnt;
    logic [IdxW-1:0]   scan_idx;

    // Negative zero (sign-magnitude 10..0, one's complement 11..1) is shown as plain 0.
    always_comb begin
        raw_neg = 1'b0;
        mag     = Data;
        if (IsSigned) begin
            raw_neg = Data[Size-1];
            if (IsStr)
                mag = {1'b0, Data[Size-2:0]};
            else if (IsInv)
                mag = raw_neg ? {1'b0, ~Data[Size-2:0]} : {1'b0, Data[Size-2:0]};
            else
                mag = raw_neg ? (~Data + Size'(1)) : Data;
        end
        neg = raw_neg && (mag != '0);
    end

    assign start = (state == IDLE) && !eng_busy && ((Data != last) || force_q);

    bin2bcd_seq #(
        .MagW (MagW),
        .BcdD (BcdD)
    ) u_bin2bcd (
        .Clock (Clock),
        .Reset (Reset),
        .start (start),
        .bin   (mag),
        .busy  (eng_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Digit images for the LOAD cycle: sign slot, leading-zero blanking, overflow dashes.
    always_comb begin
        ovf  = 1'b0;
        lead = 1'b1;
        nib  = 4'd0;
        for (int i = NumD; i < BcdD; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                ovf = 1'b1;
        end
        for (int i = Digits - 1; i >= 0; i--) begin
            nib = 4'(bcd >> (4 * i));
            if (IsSigned && i == Digits - 1) begin
                next_digit[i] = neg_q ? SEG_MINUS : SEG_BLANK;
            end else if (lead && nib == 4'd0 && i != 0) begin
                next_digit[i] = SEG_BLANK;
            end else begin
                lead          = 1'b0;
                next_digit[i] = bcd_to_seg(nib);
            end
            if (ovf)
                next_digit[i] = SEG_MINUS;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            last     <= '0;
            force_q  <= 1'b1;
            neg_q    <= 1'b0;
            Busy     <= 1'b0;
            Overflow <= 1'b0;
            for (int i = 0; i < Digits; i++)
                digit_q[i] <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last    <= Data;
                        force_q <= 1'b0;
                        neg_q   <= neg;
                        Busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    if (conv_done)
                        state <= LOAD;
                end
                LOAD: begin
                    Overflow <= ovf;
                    for (int i = 0; i < Digits; i++)
                        digit_q[i] <= next_digit[i];
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select and segment outputs come from the same index so they change together.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            Segments <= SEG_BLANK;
            DigitSel <= '1;
        end else begin
            if (scan_cnt == ScanW'(ScanDiv - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IdxW'(Digits - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            DigitSel <= ~(Digits'(1) << scan_idx);
            Segments <= digit_q[scan_idx];
        end
    end

endmodule

// File: tb/tb_coded_data_display.sv
// tb/tb_coded_data_display.sv - scoreboard bench for coded_data_display across four encodings
module tb_coded_data_display;

    typedef struct packed {
        logic            ovf;
        logic [2:0][6:0] seg;
    } exp_t;

    logic       Clock;
    logic       Reset;
    logic [4:0] data5;
    logic [7:0] data8;

    logic [6:0] seg_a, seg_b, seg_c, seg_d;
    logic [2:0] sel_a, sel_b, sel_c;
    logic [1:0] sel_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t cur_a;

    coded_data_display #(.Size(5), .Signed("Yes"), .Code("Two"), .Digits(3), .ScanDiv(4)) u_a (
        .Clock(Clock), .Reset(Reset), .Data(data5), .Segments(seg_a), .DigitSel(sel_a),
        .Busy(busy_a), .Overflow(ovf_a));
    coded_data_display #(.Size(5), .Signed("Yes"), .Code("Str"), .Digits(3), .ScanDiv(4)) u_b (
        .Clock(Clock), .Reset(Reset), .Data(data5), .Segments(seg_b), .DigitSel(sel_b),
        .Busy(busy_b), .Overflow(ovf_b));
    coded_data_display #(.Size(5), .Signed("Yes"), .Code("Inv"), .Digits(3), .ScanDiv(4)) u_c (
        .Clock(Clock), .Reset(Reset), .Data(data5), .Segments(seg_c), .DigitSel(sel_c),
        .Busy(busy_c), .Overflow(ovf_c));
    coded_data_display #(.Size(8), .Signed("No"), .Code("Str"), .Digits(2), .ScanDiv(3)) u_d (
        .Clock(Clock), .Reset(Reset), .Data(data8), .Segments(seg_d), .DigitSel(sel_d),
        .Busy(busy_d), .Overflow(ovf_d));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    logic [3:0]      busy_v;
    logic [3:0]      ovf_v;
    logic [2:0][6:0] act_dig [4];

    assign busy_v = {busy_d, busy_c, busy_b, busy_a};
    assign ovf_v  = {ovf_d, ovf_c, ovf_b, ovf_a};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            act_dig[0][i] = u_a.digit_q[i];
            act_dig[1][i] = u_b.digit_q[i];
            act_dig[2][i] = u_c.digit_q[i];
        end
        act_dig[3][0] = u_d.digit_q[0];
        act_dig[3][1] = u_d.digit_q[1];
        act_dig[3][2] = 7'h7F;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    // code: 0 sign-magnitude, 1 one's complement, 2 two's complement
    function automatic exp_t model(input int size, input bit sgn, input int code,
                                   input int digits, input int data);
        exp_t e;
        int   v, mag, numd, p;
        bit   neg;
        v = data;
        if (sgn && ((data >> (size - 1)) & 1) == 1) begin
            case (code)
                0:       v = -(data - (1 << (size - 1)));
                1:       v = -(((1 << size) - 1) - data);
                default: v = data - (1 << size);
            endcase
        end
        neg  = (v < 0);
        mag  = neg ? -v : v;
        numd = sgn ? digits - 1 : digits;
        p = 1;
        for (int i = 0; i < numd; i++) p = p * 10;
        e.ovf = (mag >= p);
        for (int i = 0; i < 3; i++) e.seg[i] = 7'h7F;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            if (e.ovf)                            e.seg[i] = 7'h3F;
            else if (sgn && i == digits - 1)      e.seg[i] = neg ? 7'h3F : 7'h7F;
            else if (i == 0 || mag >= p)          e.seg[i] = seg_of((mag / p) % 10);
            p = p * 10;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push5(input logic [4:0] a);
        q0.push_back(model(5, 1'b1, 2, 3, int'(a)));
        q1.push_back(model(5, 1'b1, 0, 3, int'(a)));
        q2.push_back(model(5, 1'b1, 1, 3, int'(a)));
        cur_a = model(5, 1'b1, 2, 3, int'(a));
    endtask

    task automatic push8(input logic [7:0] d);
        q3.push_back(model(8, 1'b0, 2, 2, int'(d)));
    endtask

    task automatic check_done(input int k, input int blen);
        exp_t e;
        int   qsz;
        case (k)
            0: qsz = q0.size();
            1: qsz = q1.size();
            2: qsz = q2.size();
            default: qsz = q3.size();
        endcase
        if (qsz == 0) begin
            cmp($sformatf("unexpected_conv_%0d", k), 1, 0);
            return;
        end
        case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
        cmp($sformatf("busy_len_%0d", k), blen, (k == 3) ? 9 : 6);
        cmp($sformatf("overflow_%0d", k), int'(ovf_v[k]), int'(e.ovf));
        for (int i = 0; i < 3; i++)
            cmp($sformatf("digit%0d_%0d", i, k), int'(act_dig[k][i]), int'(e.seg[i]));
    endtask

    initial begin : monitor
        bit prev [4];
        int bcnt [4];
        for (int k = 0; k < 4; k++) begin prev[k] = 0; bcnt[k] = 0; end
        forever begin
            @(negedge Clock);
            for (int k = 0; k < 4; k++) begin
                if (!Reset) begin
                    prev[k] = 0;
                    bcnt[k] = 0;
                end else begin
                    if (busy_v[k]) begin
                        bcnt[k]++;
                    end else if (prev[k]) begin
                        check_done(k, bcnt[k]);
                        bcnt[k] = 0;
                    end
                    prev[k] = busy_v[k];
                end
            end
        end
    end

    task automatic apply(input logic [4:0] a, input logic [7:0] d);
        @(posedge Clock);
        #1;
        if (a != data5) push5(a);
        if (d != data8) push8(d);
        data5 = a;
        data8 = d;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int t = 0;
        repeat (2) @(posedge Clock);
        while (quiet < 3 && t < 80) begin
            @(negedge Clock);
            t++;
            quiet = (busy_v == 4'b0) ? quiet + 1 : 0;
        end
        if (quiet < 3) cmp("wait_idle_timeout", t, -1);
    endtask

    task automatic scan_check();
        int prev_idx = -1;
        int run      = 0;
        int changes  = 0;
        int idx;
        for (int s = 0; s < 30; s++) begin
            @(negedge Clock);
            case (sel_a)
                3'b110:  idx = 0;
                3'b101:  idx = 1;
                3'b011:  idx = 2;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                cmp("digitsel_onehot", int'(sel_a), 6);
            end else begin
                cmp($sformatf("scan_seg_d%0d", idx), int'(seg_a), int'(cur_a.seg[idx]));
                if (prev_idx >= 0 && idx != prev_idx) begin
                    cmp("scan_order", idx, (prev_idx + 1) % 3);
                    if (changes > 0) cmp("scan_dwell", run, 4);
                    changes++;
                    run = 0;
                end
                run++;
                prev_idx = idx;
            end
        end
        cmp("scan_advanced", int'(changes >= 5), 1);
    endtask

    initial begin : stim
        logic [4:0] ra;
        logic [7:0] rd;
        Reset = 1'b0;
        data5 = 5'd0;
        data8 = 8'd0;
        repeat (3) @(posedge Clock);
        #2;
        cmp("rst_segments", int'(seg_a), 'h7F);
        cmp("rst_digitsel", int'(sel_a), 'b111);
        cmp("rst_busy", int'(busy_a), 0);
        cmp("rst_overflow", int'(ovf_d), 0);
        @(posedge Clock);
        #1;
        push5(5'd0);
        push8(8'd0);
        Reset = 1'b1;
        wait_idle();

        apply(5'b11101, 8'd255); wait_idle();
        apply(5'b10000, 8'd42);  wait_idle();
        apply(5'b11111, 8'd99);  wait_idle();
        apply(5'b10110, 8'd100);
        apply(5'b00111, 8'd7);   wait_idle();
        scan_check();

        apply(5'b01100, 8'd200);
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        cmp("midconv_rst_digitsel", int'(sel_a), 'b111);
        cmp("midconv_rst_segments", int'(seg_a), 'h7F);
        cmp("midconv_rst_busy", int'(busy_a), 0);
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        @(posedge Clock);
        #1;
        push5(data5);
        push8(data8);
        Reset = 1'b1;
        wait_idle();

        for (int it = 0; it < 30; it++) begin
            ra = 5'($urandom);
            rd = 8'($urandom);
            apply(ra, rd);
            if ($urandom_range(0, 2) == 0) begin
                ra = 5'($urandom);
                rd = 8'($urandom);
                apply(ra, rd);
            end
            wait_idle();
        end
        scan_check();

        wait_idle();
        cmp("drain_q0", q0.size(), 0);
        cmp("drain_q1", q1.size(), 0);
        cmp("drain_q2", q2.size(), 0);
        cmp("drain_q3", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
